// File: rtl/csr_file.sv
// Machine-mode CSR storage and execute unit: atomic read-modify-write, 64-bit
// cycle/instret counters, and trap-entry / mret updates of the M-mode state.
module csr_file #(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_valid,
    input  logic        csr_read_enable,
    input  logic        csr_write_enable,
    input  logic [1:0]  csr_write_func,
    input  logic        csr_input_select,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_value,
    input  logic [4:0]  uimm,
    input  logic        instr_retired,
    input  logic        trap_enter,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic        csr_rdata_valid,
    output logic        csr_illegal,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_out
);

    typedef enum logic [1:0] {
        FN_NONE = 2'd0,
        FN_RW   = 2'd1,
        FN_RS   = 2'd2,
        FN_RC   = 2'd3
    } func_e;

    func_e       func;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d, illegal_q, illegal_d;

    logic        mapped, accept, wr_en, rd_ok;
    logic [31:0] old_val, src, new_val;

    assign func = func_e'(csr_write_func);

    always_comb begin
        mapped  = 1'b1;
        old_val = '0;
        case (csr_addr)
            12'h300: old_val = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h301: old_val = MISA_VALUE;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h343: old_val = mtval_q;
            12'hB00, 12'hC00: old_val = mcycle_q[31:0];
            12'hB02, 12'hC02: old_val = minstret_q[31:0];
            12'hB80, 12'hC80: old_val = mcycle_q[63:32];
            12'hB82, 12'hC82: old_val = minstret_q[63:32];
            12'hF14: old_val = HART_ID;
            default: mapped = 1'b0;
        endcase
    end

    always_comb begin
        src = csr_input_select ? {27'b0, uimm} : rs1_value;
        case (func)
            FN_RS:   new_val = old_val | src;
            FN_RC:   new_val = old_val & ~src;
            default: new_val = src;
        endcase
    end

    always_comb begin
        accept    = csr_valid && (func != FN_NONE);
        illegal_d = accept && (((csr_read_enable || csr_write_enable) && !mapped) ||
                               (csr_write_enable && (csr_addr[11:10] == 2'b11)));
        wr_en     = accept && csr_write_enable && !illegal_d;
        rd_ok     = accept && csr_read_enable && !illegal_d;
        rdata_d   = rd_ok ? old_val : '0;
        rvalid_d  = rd_ok;
    end

    // Trap entry beats mret beats the CSR write, resolved per register; the
    // read path above always sees the pre-edge value.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = instr_retired ? minstret_q + 64'd1 : minstret_q;

        if (wr_en) begin
            case (csr_addr)
                12'h300: begin
                    mie_d  = new_val[3];
                    mpie_d = new_val[7];
                end
                12'h305: mtvec_d    = {new_val[31:2], 1'b0, new_val[0]};
                12'h340: mscratch_d = new_val;
                12'h341: mepc_d     = {new_val[31:2], 2'b00};
                12'h342: mcause_d   = new_val;
                12'h343: mtval_d    = new_val;
                12'hB00: mcycle_d   = {mcycle_q[63:32], new_val};
                12'hB80: mcycle_d   = {new_val, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], new_val};
                12'hB82: minstret_d = {new_val, minstret_q[31:0]};
                default: ;
            endcase
        end

        if (trap_enter) begin
            mepc_d   = {trap_pc[31:2], 2'b00};
            mcause_d = trap_cause;
            mtval_d  = trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            illegal_q  <= illegal_d;
        end
    end

    assign csr_rdata       = rdata_q;
    assign csr_rdata_valid = rvalid_q;
    assign csr_illegal     = illegal_q;
    assign mtvec_out       = mtvec_q;
    assign mepc_out        = mepc_q;
    assign mie_out         = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed, table-driven bench for csr_file with hand-computed expectations
// plus hand-written counter, minstret and mid-op reset sequences.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_valid = 1'b0, csr_read_enable = 1'b0, csr_write_enable = 1'b0;
    logic [1:0]  csr_write_func = 2'd0;
    logic        csr_input_select = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] rs1_value = '0;
    logic [4:0]  uimm = '0;
    logic        instr_retired = 1'b0, trap_enter = 1'b0, mret = 1'b0;
    logic [31:0] trap_cause = 32'd2, trap_pc = 32'h8000_0006, trap_tval = 32'h0000_0ABC;
    logic [31:0] csr_rdata, mtvec_out, mepc_out;
    logic        csr_rdata_valid, csr_illegal, mie_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    csr_file #(.HART_ID(32'd0), .MISA_VALUE(32'h4000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .csr_valid(csr_valid),
        .csr_read_enable(csr_read_enable), .csr_write_enable(csr_write_enable),
        .csr_write_func(csr_write_func), .csr_input_select(csr_input_select),
        .csr_addr(csr_addr), .rs1_value(rs1_value), .uimm(uimm),
        .instr_retired(instr_retired), .trap_enter(trap_enter),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret(mret), .csr_rdata(csr_rdata), .csr_rdata_valid(csr_rdata_valid),
        .csr_illegal(csr_illegal), .mtvec_out(mtvec_out), .mepc_out(mepc_out),
        .mie_out(mie_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, re, we;
        logic [1:0]  fn;
        logic        sel;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  uimm;
        logic        trap, mret;
        logic [31:0] exp_rd;
        logic        exp_v, exp_ill;
    } vec_t;

    localparam logic [1:0] NONE = 2'd0, RW = 2'd1, RS = 2'd2, RC = 2'd3;

    function automatic vec_t mk(logic v, logic re, logic we, logic [1:0] fn, logic sel,
                                logic [11:0] addr, logic [31:0] rs1, logic [4:0] u,
                                logic trap, logic mr, logic [31:0] exp_rd,
                                logic exp_v, logic exp_ill);
        vec_t t;
        t.v = v; t.re = re; t.we = we; t.fn = fn; t.sel = sel; t.addr = addr;
        t.rs1 = rs1; t.uimm = u; t.trap = trap; t.mret = mr;
        t.exp_rd = exp_rd; t.exp_v = exp_v; t.exp_ill = exp_ill;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        csr_valid        = t.v;
        csr_read_enable  = t.re;
        csr_write_enable = t.we;
        csr_write_func   = t.fn;
        csr_input_select = t.sel;
        csr_addr         = t.addr;
        rs1_value        = t.rs1;
        uimm             = t.uimm;
        trap_enter       = t.trap;
        mret             = t.mret;
    endtask

    // One op per clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic do_op(input vec_t t, input string name);
        @(negedge clk);
        drive(t);
        @(posedge clk);
        #1;
        chk({name, "_rdata"},   csr_rdata,             t.exp_rd);
        chk({name, "_valid"},   {31'b0, csr_rdata_valid}, {31'b0, t.exp_v});
        chk({name, "_illegal"}, {31'b0, csr_illegal},  {31'b0, t.exp_ill});
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        do_op(mk(1, 1, 0, RS, 0, a, 0, 0, 0, 0, exp, 1, 0), name);
    endtask

    vec_t tbl[$];

    initial begin
        // mscratch read-modify-write chain
        tbl.push_back(mk(1,1,1,RW,0,12'h340,32'h0,       0,   0,0, 32'h0,        1,0));
        tbl.push_back(mk(1,1,1,RW,0,12'h340,32'hDEADBEEF,0,   0,0, 32'h0,        1,0));
        tbl.push_back(mk(1,1,1,RS,1,12'h340,32'h0,       5'h10,0,0,32'hDEADBEEF, 1,0));
        tbl.push_back(mk(1,1,1,RC,0,12'h340,32'hFF,      0,   0,0, 32'hDEADBEFF, 1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h340,32'h0,       0,   0,0, 32'hDEADBE00, 1,0));
        tbl.push_back(mk(1,0,1,RW,0,12'h340,32'h12345678,0,   0,0, 32'h0,        0,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h340,32'h0,       0,   0,0, 32'h12345678, 1,0));
        // misa WARL, mhartid read-only, mtvec/mepc hardwired bits
        tbl.push_back(mk(1,1,1,RW,0,12'h301,32'h0,       0,   0,0, 32'h40000100, 1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h301,32'h0,       0,   0,0, 32'h40000100, 1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'hF14,32'h0,       0,   0,0, 32'h0,        1,0));
        tbl.push_back(mk(1,1,1,RW,0,12'hF14,32'h5,       0,   0,0, 32'h0,        0,1));
        tbl.push_back(mk(1,1,1,RW,0,12'h305,32'hFFFFFFFF,0,   0,0, 32'h0,        1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h305,32'h0,       0,   0,0, 32'hFFFFFFFD, 1,0));
        tbl.push_back(mk(1,1,1,RW,0,12'h341,32'hFFFFFFFF,0,   0,0, 32'h0,        1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h341,32'h0,       0,   0,0, 32'hFFFFFFFC, 1,0));
        // minstret write, read-only alias, illegal alias write
        tbl.push_back(mk(1,1,1,RW,0,12'hB02,32'h5,       0,   0,0, 32'h0,        1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'hB02,32'h0,       0,   0,0, 32'h5,        1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'hC02,32'h0,       0,   0,0, 32'h5,        1,0));
        tbl.push_back(mk(1,1,1,RW,0,12'hC02,32'h0,       0,   0,0, 32'h0,        0,1));
        tbl.push_back(mk(1,1,0,RS,0,12'hB02,32'h0,       0,   0,0, 32'h5,        1,0));
        // unmapped, NONE func, not-valid
        tbl.push_back(mk(1,1,0,RS,0,12'h7FF,32'h0,       0,   0,0, 32'h0,        0,1));
        tbl.push_back(mk(1,0,1,RW,0,12'h7FF,32'h1,       0,   0,0, 32'h0,        0,1));
        tbl.push_back(mk(1,1,0,NONE,0,12'h340,32'h0,     0,   0,0, 32'h0,        0,0));
        tbl.push_back(mk(0,1,1,RW,0,12'h340,32'h0,       0,   0,0, 32'h0,        0,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h340,32'h0,       0,   0,0, 32'h12345678, 1,0));
        tbl.push_back(mk(1,1,1,RW,0,12'h300,32'hFFFFFFFF,0,   0,0, 32'h0,        1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h300,32'h0,       0,   0,0, 32'h88,       1,0));
        tbl.push_back(mk(1,0,1,RW,0,12'h342,32'h7,       0,   0,0, 32'h0,        0,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h342,32'h0,       0,   0,0, 32'h7,        1,0));
        // mcycle wrap into mcycleh (back-to-back ops, one cycle each)
        tbl.push_back(mk(1,0,1,RW,0,12'hB80,32'h0,       0,   0,0, 32'h0,        0,0));
        tbl.push_back(mk(1,0,1,RW,0,12'hB00,32'hFFFFFFFE,0,   0,0, 32'h0,        0,0));
        tbl.push_back(mk(1,1,0,RS,0,12'hB00,32'h0,       0,   0,0, 32'hFFFFFFFE, 1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'hB00,32'h0,       0,   0,0, 32'hFFFFFFFF, 1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'hB80,32'h0,       0,   0,0, 32'h1,        1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'hC80,32'h0,       0,   0,0, 32'h1,        1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'hC00,32'h0,       0,   0,0, 32'h2,        1,0));
        tbl.push_back(mk(1,1,1,RW,0,12'hC00,32'h0,       0,   0,0, 32'h0,        0,1));
        tbl.push_back(mk(1,1,0,RS,0,12'hB00,32'h0,       0,   0,0, 32'h4,        1,0));
        // trap entry / mret interplay
        tbl.push_back(mk(1,1,1,RW,0,12'h300,32'h0,       0,   0,0, 32'h88,       1,0));
        tbl.push_back(mk(1,1,1,RS,1,12'h300,32'h0,       5'h8,0,0, 32'h0,        1,0));
        tbl.push_back(mk(1,1,1,RW,0,12'h341,32'h1234,    0,   1,0, 32'hFFFFFFFC, 1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h341,32'h0,       0,   0,0, 32'h80000004, 1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h342,32'h0,       0,   0,0, 32'h2,        1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h343,32'h0,       0,   0,0, 32'hABC,      1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h300,32'h0,       0,   0,0, 32'h80,       1,0));
        tbl.push_back(mk(0,0,0,NONE,0,12'h0,32'h0,       0,   0,1, 32'h0,        0,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h300,32'h0,       0,   0,0, 32'h88,       1,0));
        tbl.push_back(mk(0,0,0,NONE,0,12'h0,32'h0,       0,   1,1, 32'h0,        0,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h300,32'h0,       0,   0,0, 32'h80,       1,0));
        tbl.push_back(mk(1,1,1,RW,0,12'h300,32'h0,       0,   0,1, 32'h80,       1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h300,32'h0,       0,   0,0, 32'h88,       1,0));
        tbl.push_back(mk(1,1,1,RW,0,12'h340,32'hAAAA,    0,   1,0, 32'h12345678, 1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h340,32'h0,       0,   0,0, 32'hAAAA,     1,0));
        tbl.push_back(mk(1,1,0,RS,0,12'h300,32'h0,       0,   0,0, 32'h80,       1,0));
        tbl.push_back(mk(0,0,0,NONE,0,12'h0,32'h0,       0,   0,1, 32'h0,        0,0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", csr_rdata, 32'h0);
        chk("reset_valid", {31'b0, csr_rdata_valid}, 32'h0);
        chk("reset_illegal", {31'b0, csr_illegal}, 32'h0);
        chk("reset_mtvec", mtvec_out, 32'h0);
        chk("reset_mepc", mepc_out, 32'h0);
        chk("reset_mie", {31'b0, mie_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i));

        @(negedge clk);
        drive(mk(0,0,0,NONE,0,12'h0,32'h0,0,0,0,32'h0,0,0));
        chk("post_mie", {31'b0, mie_out}, 32'h1);
        chk("post_mepc", mepc_out, 32'h80000004);
        chk("post_mtvec", mtvec_out, 32'hFFFFFFFD);

        // minstret counts only retiring cycles; a write cycle suppresses the increment
        @(posedge clk);
        #1;
        instr_retired = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        instr_retired = 1'b0;
        rd(12'hB02, 32'h8, "minstret_count");
        instr_retired = 1'b1;
        do_op(mk(1,0,1,RW,0,12'hB02,32'h0,0,0,0,32'h0,0,0), "minstret_wr");
        instr_retired = 1'b0;
        rd(12'hB02, 32'h0, "minstret_after_wr");

        // Reset asserted in the middle of a write op discards write and response
        @(negedge clk);
        drive(mk(1,1,1,RW,0,12'h305,32'h100,0,0,0,32'h0,0,0));
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_valid", {31'b0, csr_rdata_valid}, 32'h0);
        chk("midreset_mtvec", mtvec_out, 32'h0);
        @(negedge clk);
        drive(mk(0,0,0,NONE,0,12'h0,32'h0,0,0,0,32'h0,0,0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postreset_mtvec", mtvec_out, 32'h0);
        chk("postreset_valid", {31'b0, csr_rdata_valid}, 32'h0);
        chk("postreset_mie", {31'b0, mie_out}, 32'h0);
        chk("postreset_mepc", mepc_out, 32'h0);
        rd(12'h305, 32'h0, "postreset_mtvec_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR storage and execute unit. It consumes the decoded CSR parameters (read_enable, write_enable, input_select, write_func) produced in writeback.
- It performs the atomic read-modify-write and returns the old CSR value for the rd write.
- It owns the cycle and instret counters and the trap-entry/mret state updates. Single hart, sits beside the register file in writeback.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14).
- MISA_VALUE, 32'h4000_0100, read-only misa value (RV32I).

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- csr_valid  in  1  CSR op presented this cycle.
- csr_read_enable  in  1  decoded read enable.
- csr_write_enable  in  1  decoded write enable.
- csr_write_func  in  2  0 NONE, 1 RW, 2 RS, 3 RC (funct3[1:0]).
- csr_input_select  in  1  0 = rs1_value, 1 = zero-extended uimm.
- csr_addr  in  12  CSR address.
- rs1_value  in  32  register source.
- uimm  in  5  immediate source.
- instr_retired  in  1  one instruction retired this cycle.
- trap_enter  in  1  take trap this cycle.
- trap_cause  in  32  mcause value.
- trap_pc  in  32  faulting PC.
- trap_tval  in  32  mtval value.
- mret  in  1  mret retiring.
- csr_rdata  out  32  old CSR value.
- csr_rdata_valid  out  1  rdata valid (read_enable was set).
- csr_illegal  out  1  illegal CSR access.
- mtvec_out  out  32  current mtvec.
- mepc_out  out  32  current mepc.
- mie_out  out  1  mstatus.MIE.

Behaviour:
- CSR map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are stored; all other bits read 0.
  - misa 0x301: reads MISA_VALUE; writes are ignored without an illegal flag (WARL).
  - mtvec 0x305: bit 1 is hardwired 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] are hardwired 0.
  - mcause 0x342, mtval 0x343.
  - mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
  - cycle, instret, cycleh, instreth at 0xC00, 0xC02, 0xC80, 0xC82: read-only aliases.
  - mhartid 0xF14: reads HART_ID.
- Source selection: src = csr_input_select ? {27'b0, uimm} : rs1_value.
- New value:
  - RW: new = src.
  - RS: new = old | src.
  - RC: new = old & ~src.
  - Masking of hardwired bits is applied after computing new.
- Op qualification: an op is accepted only when csr_valid=1 and csr_write_func != NONE. All effects are gated on csr_valid.
- Latency: exactly 1 cycle, no backpressure.
  - csr_rdata and csr_rdata_valid are registered and valid the cycle after csr_valid.
  - rdata is the pre-write value of the same op.
  - When read_enable=0: rdata=0, rdata_valid=0.
- Illegal access (csr_illegal pulses 1 cycle later, no state changes, rdata=0, rdata_valid=0):
  - unmapped address with read or write enable;
  - write_enable=1 to an address with addr[11:10]==2'b11.
- Write timing: the CSR write commits at the clock edge ending the csr_valid cycle.
- Counters (64-bit mcycle, minstret):
  - mcycle increments every cycle; minstret increments when instr_retired=1.
  - Both wrap from 2^64-1 to 0.
  - A write to the low or high half replaces that half. That counter does not increment in the write cycle; the other half is untouched.
- trap_enter:
  - mepc <= {trap_pc[31:2], 2'b00}, mcause <= trap_cause, mtval <= trap_tval.
  - MPIE <= MIE, MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1.
- Priority: trap_enter > mret > CSR write, applied per affected register. The CSR read still returns the pre-edge value.
- trap_enter and mret together: trap_enter wins, mret is ignored.
- Reset values (async on rst_n low):
  - All CSRs 0, mtvec 0.
  - csr_rdata 0, csr_rdata_valid 0, csr_illegal 0.
  - mie_out 0, mtvec_out 0, mepc_out 0.
  - Reset mid-op discards the pending write and response.
- mtvec_out, mepc_out and mie_out are direct register outputs; they update the cycle after a write.

Test Plan:
- Reset release, then read mscratch (0x340) RW with rd!=x0 -> next cycle rdata=0, rdata_valid=1, no illegal.
- Write mscratch RW rs1=0xDEADBEEF; then RS uimm=0x10; then RC rs1=0x0000_00FF:
  - RS returns 0xDEADBEEF;
  - RC returns 0xDEADBEFF;
  - final read = 0xDEADBE00.
- Hold mcycle with write mcycle=0xFFFF_FFFE and mcycleh=0x0; read mcycle 3 cycles later -> shows the increment 0xFFFF_FFFF, then carry into mcycleh=1 after wrap.
- Write 0xC00 (cycle) with RW -> csr_illegal=1 next cycle, rdata_valid=0, counter unchanged. Same for addr 0x7FF with a read -> illegal.
- MIE=1 via RS mstatus uimm=0x8, then trap_enter pc=0x8000_0006, cause=0x2 in the same cycle as a mepc write of 0x1234 -> mepc=0x8000_0004, mcause=2, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
- Assert rst_n low one cycle after csr_valid (write mtvec=0x100) -> mtvec_out=0 and rdata_valid=0 after reset.
